// File: rtl/cv32e40p_pdl3_pkg.sv
// cv32e40p_pdl3_pkg
// Shared constants and types for the PDL3 clock-glitch detector.
//   PDL3_NUM_STAGES     : default number of delay stages in the chain
//   PDL3_STAGE_DELAY_PS : default per-stage delay used by the simulation model
//   pdl3_state_t        : registered detector state (toggle, armed, alarm)
`timescale 1ps/1ps
package cv32e40p_pdl3_pkg;

    localparam int PDL3_NUM_STAGES     = 8;
    localparam int PDL3_STAGE_DELAY_PS = 1000;

    typedef struct packed {
        logic q1;
        logic armed;
        logic alarm;
    } pdl3_state_t;

endpackage

// File: rtl/cv32e40p_pdl3_delay_stage.sv
// cv32e40p_pdl3_delay_stage
// One non-inverting stage of the propagation-delay line. The buffer net
// carries keep/dont_touch so the chain survives synthesis. In simulation
// the stage applies an inertial delay of STAGE_DELAY_PS picoseconds.
// Ports:
//   din  : stage input (previous stage or toggle flop)
//   dout : stage output (next stage or chain tail)
`timescale 1ps/1ps
module cv32e40p_pdl3_delay_stage
    import cv32e40p_pdl3_pkg::*;
#(
    parameter int STAGE_DELAY_PS = PDL3_STAGE_DELAY_PS
) (
    input  logic din,
    output logic dout
);

    (* keep = "true", dont_touch = "true" *) logic buf_w;

    // Synthesis sees a plain kept buffer; simulation models the physical
    // propagation delay of the cell.
`ifdef SYNTHESIS
    assign buf_w = din;
`else
    assign #(STAGE_DELAY_PS) buf_w = din;
`endif

    assign dout = buf_w;

endmodule

// File: rtl/cv32e40p_pdl3.sv
// cv32e40p_pdl3
// Clock-glitch detector built around a propagation-delay line. A toggle
// flop feeds NUM_STAGES delay stages; on every rising edge the tail of the
// chain must already show the toggle's previous value, otherwise the last
// clock interval was shorter than the chain delay and a glitch is flagged.
// Ports:
//   clk        : monitored clock
//   rst_n      : synchronous reset, ACTIVE-HIGH despite its name
//   Q1         : toggle flop output, head of the delay line
//   delay_line : tail of the delay line
//   alarm      : glitch detected (registered)
// Configuration macro:
//   CV32E40P_PDL3_STICKY_ALARM_EN : defined -> alarm holds until reset,
//                                   undefined -> one-cycle pulse per bad edge
`timescale 1ps/1ps
module cv32e40p_pdl3
    import cv32e40p_pdl3_pkg::*;
#(
    parameter int NUM_STAGES     = PDL3_NUM_STAGES,
    parameter int STAGE_DELAY_PS = PDL3_STAGE_DELAY_PS
) (
    input  logic clk,
    input  logic rst_n,
    output logic Q1,
    output logic delay_line,
    output logic alarm
);

    pdl3_state_t state_q;
    pdl3_state_t state_d;
    logic        mismatch;
    logic [NUM_STAGES:0] chain;

    assign chain[0] = state_q.q1;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        cv32e40p_pdl3_delay_stage #(
            .STAGE_DELAY_PS(STAGE_DELAY_PS)
        ) u_stage (
            .din  (chain[i]),
            .dout (chain[i+1])
        );
    end

    assign delay_line = chain[NUM_STAGES];

    // state_q.q1 is still the pre-edge toggle value here, so a healthy
    // interval means the chain tail has caught up with it. The first edge
    // after reset is skipped because the chain was only settled to 0.
    always_comb begin
        mismatch      = state_q.armed && (delay_line != state_q.q1);
        state_d.q1    = ~state_q.q1;
        state_d.armed = 1'b1;
`ifdef CV32E40P_PDL3_STICKY_ALARM_EN
        state_d.alarm = state_q.alarm | mismatch;
`else
        state_d.alarm = mismatch;
`endif
    end

    // rst_n is active-high: a 1 clears the toggle, arming and alarm.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign Q1    = state_q.q1;
    assign alarm = state_q.alarm;

endmodule

// File: tb/tb_cv32e40p_pdl3.sv
// tb_cv32e40p_pdl3
// Testbench for the PDL3 clock-glitch detector. The clock is generated
// edge by edge so each rising-edge interval can be chosen freely. The
// reference model keeps a time history of the toggle value and decides
// a glitch purely from "did the toggle change within the last chain
// delay before this edge".
`timescale 1ps/1ps
module tb_cv32e40p_pdl3;
    import cv32e40p_pdl3_pkg::*;

    localparam longint CHAIN_PS = PDL3_NUM_STAGES * PDL3_STAGE_DELAY_PS;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic q1;
    logic delayLine;
    logic alarm;

    logic clk4  = 1'b0;
    logic rst4  = 1'b1;
    logic q14;
    logic delayLine4;
    logic alarm4;

    int checkCount = 0;
    int passCount  = 0;

    bit     modelQ1    = 1'b0;
    bit     modelArmed = 1'b0;
    bit     modelAlarm = 1'b0;
    longint chTime[$];
    bit     chVal[$];
    longint lastRise    = 0;
    longint settledTime = -1;

    cv32e40p_pdl3 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Q1         (q1),
        .delay_line (delayLine),
        .alarm      (alarm)
    );

    cv32e40p_pdl3 #(
        .NUM_STAGES     (4),
        .STAGE_DELAY_PS (1000)
    ) dut4 (
        .clk        (clk4),
        .rst_n      (rst4),
        .Q1         (q14),
        .delay_line (delayLine4),
        .alarm      (alarm4)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %b expected %b at %0t ps", tag, observed, expected, $time);
        end
    endtask

    task automatic waitUntil(input longint t);
        if (t > longint'($time)) #(t - longint'($time));
    endtask

    // Toggle value as seen at absolute time t, from the change history.
    function automatic bit valueAt(input longint t);
        bit v = 1'b0;
        foreach (chTime[i]) begin
            if (chTime[i] <= t) v = chVal[i];
        end
        return v;
    endfunction

    // A tail sample is only meaningful once the chain has settled after the
    // first reset and when no toggle change sits near the sampled instant.
    function automatic bit lineStable(input longint t);
        if (settledTime < 0 || (t + CHAIN_PS) < settledTime) return 1'b0;
        foreach (chTime[i]) begin
            if (chTime[i] > t - 400 && chTime[i] < t + 400) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic lineProbe(input string tag);
        longint t;
        t = longint'($time) - CHAIN_PS;
        if (lineStable(t)) checkOutput(tag, delayLine, valueAt(t));
    endtask

    // Reference behaviour at a rising edge: the edge is bad when the toggle
    // changed less than one chain delay ago.
    task automatic modelEdge(input bit rst);
        longint now;
        bit     pre;
        bit     bad;
        now = longint'($time);
        pre = modelQ1;
        if (rst) begin
            modelQ1    = 1'b0;
            modelArmed = 1'b0;
            modelAlarm = 1'b0;
        end else begin
            bad = modelArmed && (valueAt(now - CHAIN_PS) != pre);
`ifdef CV32E40P_PDL3_STICKY_ALARM_EN
            modelAlarm = modelAlarm | bad;
`else
            modelAlarm = bad;
`endif
            modelArmed = 1'b1;
            modelQ1    = ~pre;
        end
        if (chVal.size() == 0) begin
            chTime.push_back(now);
            chVal.push_back(modelQ1);
            settledTime = now + CHAIN_PS;
        end else if (chVal[$] != modelQ1) begin
            chTime.push_back(now);
            chVal.push_back(modelQ1);
        end
    endtask

    // Produce the next rising edge exactly gap ps after the previous one,
    // probing the chain tail just before and after its expected arrival.
    task automatic applyStimulus(input int gap, input bit rst, input string tag);
        rst_n = rst;
        waitUntil(lastRise + gap / 2);
        clk = 1'b0;
        if (gap >= 9000) begin
            waitUntil(lastRise + CHAIN_PS - 500);
            lineProbe({tag, "_lineEarly"});
            waitUntil(lastRise + CHAIN_PS + 500);
            lineProbe({tag, "_lineLate"});
        end
        waitUntil(lastRise + gap);
        clk = 1'b1;
        lastRise = longint'($time);
        modelEdge(rst);
        #100;
        checkOutput({tag, "_q1"}, q1, modelQ1);
        checkOutput({tag, "_alarm"}, alarm, modelAlarm);
        lineProbe({tag, "_line"});
    endtask

    task automatic edge4(input int gap, input bit rst);
        rst4 = rst;
        #(gap / 2 - 100) clk4 = 1'b0;
        #(gap - gap / 2) clk4 = 1'b1;
        #100;
    endtask

    initial begin
        int gap;
        bit rst;

        // Reset held for two edges, then released.
        applyStimulus(10000, 1'b1, "reset");
        applyStimulus(10000, 1'b1, "reset");
        checkOutput("resetQ1", q1, 1'b0);
        checkOutput("resetAlarm", alarm, 1'b0);

        repeat (100) applyStimulus(10000, 1'b0, "nominal");

        // Extra rising edge 3 ns after a normal one.
        applyStimulus(3000, 1'b0, "glitch");
        checkOutput("glitchAlarmSet", alarm, 1'b1);
        repeat (20) applyStimulus(10000, 1'b0, "postGlitch");
`ifdef CV32E40P_PDL3_STICKY_ALARM_EN
        checkOutput("stickyHeld", alarm, 1'b1);
`else
        checkOutput("pulseCleared", alarm, 1'b0);
`endif

        // One reset edge clears the alarm.
        applyStimulus(10000, 1'b1, "resetClear");
        checkOutput("resetClearAlarm", alarm, 1'b0);
        repeat (10) applyStimulus(10000, 1'b0, "afterReset");

        // Overclock to 6 ns for five edges.
        applyStimulus(6000, 1'b0, "overclock");
        checkOutput("overclockAlarmSet", alarm, 1'b1);
        repeat (4) applyStimulus(6000, 1'b0, "overclock");
        repeat (10) applyStimulus(10000, 1'b0, "recover");

        // Randomized intervals and occasional resets, keeping clear of the
        // undefined region around the chain delay.
        repeat (300) begin
            gap = int'($urandom_range(3000, 14000));
            while (gap > 7400 && gap < 8600) gap = int'($urandom_range(3000, 14000));
            rst = ($urandom_range(0, 19) == 0);
            applyStimulus(gap, rst, "random");
        end

        // Four-stage chain (4 ns): 5 ns period is safe, 3 ns is not.
        edge4(5000, 1'b1);
        edge4(5000, 1'b1);
        checkOutput("sweepResetQ1", q14, 1'b0);
        checkOutput("sweepResetAlarm", alarm4, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            edge4(5000, 1'b0);
            checkOutput("sweepQ1", q14, logic'(i % 2));
            checkOutput("sweepNoAlarm", alarm4, 1'b0);
        end
        edge4(3000, 1'b0);
        checkOutput("sweepFastAlarm", alarm4, 1'b1);
        edge4(5000, 1'b0);
`ifdef CV32E40P_PDL3_STICKY_ALARM_EN
        checkOutput("sweepAfterFast", alarm4, 1'b1);
`else
        checkOutput("sweepAfterFast", alarm4, 1'b0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
